// File: rtl/tipi_rpi_link.sv
// tipi_rpi_link: ti_ph3-clocked serial engine between TI byte latches and RPi GPIO pins.
// Define TIPI_LINK_GLITCH_FILTER_EN to require two equal samples before r_clk/r_le levels count.
module tipi_rpi_link #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic              ti_ph3,
    input  logic              r_reset,
    input  logic              r_clk,
    input  logic              r_le,
    input  logic              r_dc,
    input  logic              r_rt,
    input  logic              r_dout,
    output logic              r_din,
    input  logic [0:DATA_W-1] td_in,
    input  logic [0:DATA_W-1] tc_in,
    output logic [0:DATA_W-1] rd_out,
    output logic [0:DATA_W-1] rc_out,
    output logic              rd_strobe,
    output logic              rc_strobe,
    output logic              frame_err,
    input  logic              err_clr,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W + 2);
`ifdef TIPI_LINK_GLITCH_FILTER_EN
    localparam int ARM = SYNC_STAGES + 2;
`else
    localparam int ARM = SYNC_STAGES + 1;
`endif
    localparam int AW = $clog2(ARM + 1);

    typedef enum logic [1:0] {IDLE, TX, RX} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [0:DATA_W-1] sr;
    logic [4:0]        pins;
    logic [4:0]        sync_q [SYNC_STAGES];
    logic [4:0]        s_last;
    logic [1:0]        rise;
    logic [AW-1:0]     arm_cnt;
    logic              armed;
    logic              clk_e, le_e, dc_s, rt_s, dout_s;
    logic              set_err;

    assign pins   = {r_clk, r_le, r_dc, r_rt, r_dout};
    assign s_last = sync_q[SYNC_STAGES-1];
    assign dc_s   = s_last[2];
    assign rt_s   = s_last[1];
    assign dout_s = s_last[0];

    always_ff @(posedge ti_ph3 or posedge r_reset) begin
        if (r_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef TIPI_LINK_GLITCH_FILTER_EN
    logic [1:0] samp_q, lvl_q, lvl_n;

    // A level is accepted only when two consecutive samples agree.
    assign lvl_n = (~(s_last[4:3] ^ samp_q) & s_last[4:3])
                 | ((s_last[4:3] ^ samp_q) & lvl_q);
    assign rise  = lvl_n & ~lvl_q;

    always_ff @(posedge ti_ph3 or posedge r_reset) begin
        if (r_reset) begin
            samp_q <= '0;
            lvl_q  <= '0;
        end else begin
            samp_q <= s_last[4:3];
            lvl_q  <= lvl_n;
        end
    end
`else
    logic [1:0] prev_q;

    assign rise = s_last[4:3] & ~prev_q;

    always_ff @(posedge ti_ph3 or posedge r_reset) begin
        if (r_reset) prev_q <= '0;
        else         prev_q <= s_last[4:3];
    end
`endif

    // Keeps pins already high at release from looking like edges.
    assign armed = (arm_cnt == AW'(ARM));
    assign clk_e = rise[1] & armed;
    assign le_e  = rise[0] & armed;

    always_ff @(posedge ti_ph3 or posedge r_reset) begin
        if (r_reset)     arm_cnt <= '0;
        else if (!armed) arm_cnt <= arm_cnt + AW'(1);
    end

    always_comb begin
        set_err = 1'b0;
        if (le_e) begin
            if (clk_e) set_err = 1'b1;
            if (state == RX && rt_s && cnt != '0) set_err = 1'b1;
            if (state == RX && !rt_s && cnt != CW'(DATA_W)) set_err = 1'b1;
        end else if (clk_e && !rt_s && state == TX && cnt < CW'(DATA_W)) begin
            set_err = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge ti_ph3 or posedge r_reset) begin
        if (r_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            r_din     <= 1'b0;
            rd_out    <= '0;
            rc_out    <= '0;
            rd_strobe <= 1'b0;
            rc_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rd_strobe <= 1'b0;
            rc_strobe <= 1'b0;
            if (set_err)      frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;

            if (le_e) begin
                if (rt_s) begin
                    sr    <= dc_s ? tc_in : td_in;
                    r_din <= dc_s ? tc_in[0] : td_in[0];
                    cnt   <= '0;
                    state <= TX;
                end else if (state == RX) begin
                    if (cnt == CW'(DATA_W)) begin
                        if (dc_s) begin
                            rc_out    <= sr;
                            rc_strobe <= 1'b1;
                        end else begin
                            rd_out    <= sr;
                            rd_strobe <= 1'b1;
                        end
                    end
                    cnt   <= '0;
                    state <= IDLE;
                end
            end else if (clk_e) begin
                if (!rt_s) begin
                    if (state == RX) begin
                        sr <= {sr[1:DATA_W-1], dout_s};
                        if (cnt != CW'(DATA_W + 1)) cnt <= cnt + CW'(1);
                    end else begin
                        sr    <= {{(DATA_W-1){1'b0}}, dout_s};
                        cnt   <= CW'(1);
                        r_din <= 1'b0;
                        state <= RX;
                    end
                end else if (state == TX) begin
                    sr  <= {sr[1:DATA_W-1], 1'b0};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(DATA_W - 1)) begin
                        r_din <= 1'b0;
                        state <= IDLE;
                    end else begin
                        r_din <= sr[1];
                    end
                end
            end
        end
    end
endmodule
